// File: rtl/instr_mem_loader_pkg.sv
// -----------------------------------------------------------------------------
// instr_mem_loader_pkg
//   Shared definitions for the instruction-memory loader: FSM state encodings,
//   the HALT instruction word, and the default memory depth.
// -----------------------------------------------------------------------------
package instr_mem_loader_pkg;

  localparam int BITS_FOR_STATE_IMEM = 3;

  typedef enum logic [BITS_FOR_STATE_IMEM-1:0] {
    STATE_IMEM_IDLE    = 3'd0,
    STATE_IMEM_LOADING = 3'd1,
    STATE_IMEM_START   = 3'd2,
    STATE_IMEM_RUNNING = 3'd3,
    STATE_IMEM_HALTED  = 3'd4
  } imem_state_t;

  // All-ones word doubles as "nothing here" for fetches outside the program.
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  localparam int DEFAULT_MEM_DEPTH = 64;

endpackage

// File: rtl/instr_mem_loader_byte_assembler.sv
// -----------------------------------------------------------------------------
// instr_mem_loader_byte_assembler
//   Packs a stream of program bytes into 32-bit instruction words.
//   A word is presented (word_valid high, combinational) on the cycle its
//   fourth byte arrives, or on the cycle done arrives with a partial word
//   pending; missing bytes are zero. A byte arriving together with done is
//   included before padding.
//   Byte order: little-endian (1st byte -> [7:0]) by default; with
//   IMEM_BIG_ENDIAN_EN defined the 1st byte lands in [31:24].
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        drop any partial word (flush)
//   byte_valid   load_byte is accepted this cycle
//   load_byte    program byte
//   done         end of stream: flush a partial word
//   word         assembled word
//   word_valid   word must be written this cycle
// -----------------------------------------------------------------------------
module instr_mem_loader_byte_assembler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  load_byte,
  input  logic        done,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  cnt_r;
  logic [23:0] held_r;
  logic [31:0] held_ext_s;
  logic [7:0]  lane_s [4];

  assign held_ext_s = {8'h00, held_r};

  // Lane i (i-th byte of the word in arrival order): held byte, incoming byte, or zero pad.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      if (i < int'(cnt_r)) begin
        lane_s[i] = held_ext_s[8*i +: 8];
      end else if ((i == int'(cnt_r)) && byte_valid) begin
        lane_s[i] = load_byte;
      end else begin
        lane_s[i] = 8'h00;
      end
    end
  end

  // Word completes on the 4th byte, or on done with anything pending.
  always_comb begin
    word_valid = (byte_valid && (cnt_r == 2'd3)) ||
                 (done && (byte_valid || (cnt_r != 2'd0)));
  end

  // Map arrival-order lanes onto the word.
  always_comb begin
`ifdef IMEM_BIG_ENDIAN_EN
    word = {lane_s[0], lane_s[1], lane_s[2], lane_s[3]};
`else
    word = {lane_s[3], lane_s[2], lane_s[1], lane_s[0]};
`endif
  end

  // Byte counter and holding register for the partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= 2'd0;
      held_r <= 24'h000000;
    end else if (clear || word_valid) begin
      cnt_r  <= 2'd0;
      held_r <= 24'h000000;
    end else if (byte_valid) begin
      cnt_r <= cnt_r + 2'd1;
      case (cnt_r)
        2'd0:    held_r[7:0]   <= load_byte;
        2'd1:    held_r[15:8]  <= load_byte;
        2'd2:    held_r[23:16] <= load_byte;
        default: held_r        <= held_r;
      endcase
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// -----------------------------------------------------------------------------
// instr_mem_loader
//   Instruction-fetch responder for the PC. Loads a program byte stream from
//   the debug unit into word memory, pulses o_start when loading finishes,
//   then serves zero-latency fetches from i_pc and raises o_halt once a HALT
//   word is fetched while running.
//   Optional macro IMEM_BIG_ENDIAN_EN: big-endian byte packing (see
//   instr_mem_loader_byte_assembler).
// Ports
//   i_clk, i_reset      clock, asynchronous active-low reset
//   i_load_valid/byte   program byte stream; accepted when o_load_ready
//   i_load_done         end-of-stream pulse
//   i_flush             discard program, back to IDLE
//   i_pc                fetch byte address
//   o_load_ready        byte can be accepted
//   o_instruction       fetched word (HALT_WORD outside the program)
//   o_start             one-cycle start pulse to the PC
//   o_halt              halt to the PC (sticky until flush/reset)
//   o_full              memory completely written
//   o_word_count        number of words stored
// -----------------------------------------------------------------------------
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int PC_SIZE   = 32,
  parameter int WORD_SIZE = 32,
  parameter int MEM_DEPTH = DEFAULT_MEM_DEPTH,
  localparam int ADDR_BITS = $clog2(MEM_DEPTH)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_load_valid,
  input  logic [7:0]           i_load_byte,
  input  logic                 i_load_done,
  input  logic                 i_flush,
  input  logic [PC_SIZE-1:0]   i_pc,
  output logic                 o_load_ready,
  output logic [WORD_SIZE-1:0] o_instruction,
  output logic                 o_start,
  output logic                 o_halt,
  output logic                 o_full,
  output logic [ADDR_BITS:0]   o_word_count
);

  localparam logic [ADDR_BITS:0] PTR_FULL = (ADDR_BITS+1)'(MEM_DEPTH);
  localparam logic [ADDR_BITS:0] PTR_ONE  = (ADDR_BITS+1)'(1);
  localparam logic [ADDR_BITS:0] PTR_ZERO = (ADDR_BITS+1)'(0);

  imem_state_t          state_r, state_nxt_s;
  logic [ADDR_BITS:0]   wr_ptr_r, wr_ptr_nxt_s;
  logic                 flush_pend_r, flush_pend_nxt_s;
  logic                 ready_r, ready_nxt_s;
  logic                 full_r, full_nxt_s;
  logic                 start_r, start_nxt_s;

  logic [WORD_SIZE-1:0] mem_r [MEM_DEPTH];

  logic                 in_load_s;
  logic                 flush_eff_s;
  logic                 accept_s;
  logic                 done_s;
  logic                 we_s;
  logic                 word_valid_s;
  logic [31:0]          word_s;
  logic [ADDR_BITS-1:0] fetch_idx_s;
  logic                 pc_in_range_s;
  logic                 fetch_hit_s;
  logic                 halt_hit_s;
  logic                 unused_pc_s;

  assign in_load_s = (state_r == STATE_IMEM_IDLE) || (state_r == STATE_IMEM_LOADING);

  // A flush seen in START is held back until the start pulse has gone out.
  assign flush_eff_s = (i_flush && (state_r != STATE_IMEM_START)) || flush_pend_r;

  // ready_r already encodes "loading and not full"; flush takes precedence over loading.
  assign accept_s = i_load_valid && ready_r && in_load_s && !flush_eff_s;
  assign done_s   = i_load_done && in_load_s && !flush_eff_s;

  instr_mem_loader_byte_assembler u_byte_assembler (
    .clk        (i_clk),
    .rst_n      (i_reset),
    .clear      (flush_eff_s),
    .byte_valid (accept_s),
    .load_byte  (i_load_byte),
    .done       (done_s),
    .word       (word_s),
    .word_valid (word_valid_s)
  );

  // No wrap-around: once full, completed words are discarded.
  assign we_s = word_valid_s && (wr_ptr_r != PTR_FULL);

  // Fetch address decode; the byte offset within a word is irrelevant.
  assign fetch_idx_s   = i_pc[ADDR_BITS+1:2];
  assign pc_in_range_s = (i_pc[PC_SIZE-1:ADDR_BITS+2] == {(PC_SIZE-ADDR_BITS-2){1'b0}});
  assign fetch_hit_s   = pc_in_range_s && ({1'b0, fetch_idx_s} < wr_ptr_r);
  assign unused_pc_s   = ^i_pc[1:0];

  // Fetch mux: words beyond the loaded program (including stale ones after a flush) read as HALT.
  always_comb begin
    if (fetch_hit_s) begin
      o_instruction = mem_r[fetch_idx_s];
    end else begin
      o_instruction = HALT_WORD;
    end
  end

  assign halt_hit_s = (state_r == STATE_IMEM_RUNNING) && (o_instruction == HALT_WORD);
  assign o_halt     = halt_hit_s || (state_r == STATE_IMEM_HALTED);

  // Next state, write pointer and registered-output precompute.
  always_comb begin
    state_nxt_s      = state_r;
    flush_pend_nxt_s = 1'b0;
    wr_ptr_nxt_s     = wr_ptr_r;
    if (we_s) begin
      wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end

    case (state_r)
      STATE_IMEM_IDLE: begin
        if (flush_eff_s) begin
          state_nxt_s = STATE_IMEM_IDLE;
        end else if (done_s) begin
          state_nxt_s = STATE_IMEM_START;
        end else if (accept_s) begin
          state_nxt_s = STATE_IMEM_LOADING;
        end else begin
          state_nxt_s = STATE_IMEM_IDLE;
        end
      end
      STATE_IMEM_LOADING: begin
        if (flush_eff_s) begin
          state_nxt_s = STATE_IMEM_IDLE;
        end else if (done_s) begin
          state_nxt_s = STATE_IMEM_START;
        end else begin
          state_nxt_s = STATE_IMEM_LOADING;
        end
      end
      STATE_IMEM_START: begin
        state_nxt_s      = STATE_IMEM_RUNNING;
        flush_pend_nxt_s = i_flush;
      end
      STATE_IMEM_RUNNING: begin
        if (flush_eff_s) begin
          state_nxt_s = STATE_IMEM_IDLE;
        end else if (halt_hit_s) begin
          state_nxt_s = STATE_IMEM_HALTED;
        end else begin
          state_nxt_s = STATE_IMEM_RUNNING;
        end
      end
      STATE_IMEM_HALTED: begin
        if (flush_eff_s) begin
          state_nxt_s = STATE_IMEM_IDLE;
        end else begin
          state_nxt_s = STATE_IMEM_HALTED;
        end
      end
      default: begin
        state_nxt_s = STATE_IMEM_IDLE;
      end
    endcase

    if (flush_eff_s) begin
      wr_ptr_nxt_s = PTR_ZERO;
    end else begin
      wr_ptr_nxt_s = wr_ptr_nxt_s;
    end

    full_nxt_s  = (wr_ptr_nxt_s == PTR_FULL);
    ready_nxt_s = ((state_nxt_s == STATE_IMEM_IDLE) || (state_nxt_s == STATE_IMEM_LOADING)) &&
                  !full_nxt_s;
    start_nxt_s = (state_nxt_s == STATE_IMEM_START);
  end

  // State, pointer and output registers.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_r      <= STATE_IMEM_IDLE;
      wr_ptr_r     <= PTR_ZERO;
      flush_pend_r <= 1'b0;
      ready_r      <= 1'b0;
      full_r       <= 1'b0;
      start_r      <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      wr_ptr_r     <= wr_ptr_nxt_s;
      flush_pend_r <= flush_pend_nxt_s;
      ready_r      <= ready_nxt_s;
      full_r       <= full_nxt_s;
      start_r      <= start_nxt_s;
    end
  end

  // Program RAM; contents survive flush and reset, validity is tracked by wr_ptr_r.
  always_ff @(posedge i_clk) begin
    if (we_s) begin
      mem_r[wr_ptr_r[ADDR_BITS-1:0]] <= WORD_SIZE'(word_s);
    end
  end

  assign o_load_ready = ready_r;
  assign o_full       = full_r;
  assign o_start      = start_r;
  assign o_word_count = wr_ptr_r;

endmodule

// File: tb/tb_instr_mem_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_mem_loader
//   Directed bench with a cycle-stamped scoreboard: stimulus pushes expected
//   output values tagged with the cycle they apply to; a negedge monitor pops
//   and compares them against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_instr_mem_loader;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  localparam int S_INSTR = 0;
  localparam int S_START = 1;
  localparam int S_HALT  = 2;
  localparam int S_FULL  = 3;
  localparam int S_COUNT = 4;
  localparam int S_READY = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid = 1'b0;
  logic [7:0]  load_byte = 8'h00;
  logic        load_done = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] pc = 32'h0;
  logic        load_ready;
  logic [31:0] instruction;
  logic        start;
  logic        halt;
  logic        full;
  logic [6:0]  word_count;

  instr_mem_loader dut (
    .i_clk         (clk),
    .i_reset       (rst_n),
    .i_load_valid  (load_valid),
    .i_load_byte   (load_byte),
    .i_load_done   (load_done),
    .i_flush       (flush),
    .i_pc          (pc),
    .o_load_ready  (load_ready),
    .o_instruction (instruction),
    .o_start       (start),
    .o_halt        (halt),
    .o_full        (full),
    .o_word_count  (word_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        cur;
  logic [31:0] act;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] actual_of(input int sel);
    case (sel)
      S_INSTR: return instruction;
      S_START: return {31'd0, start};
      S_HALT:  return {31'd0, halt};
      S_FULL:  return {31'd0, full};
      S_COUNT: return {25'd0, word_count};
      default: return {31'd0, load_ready};
    endcase
  endfunction

  function automatic string name_of(input int sel);
    case (sel)
      S_INSTR: return "o_instruction";
      S_START: return "o_start";
      S_HALT:  return "o_halt";
      S_FULL:  return "o_full";
      S_COUNT: return "o_word_count";
      default: return "o_load_ready";
    endcase
  endfunction

  // Monitor: compare every expectation due in this cycle.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      cur = sb_q.pop_front();
      act = actual_of(cur.sel);
      checks++;
      if (cur.cyc != cyc || act !== cur.val) begin
        errors++;
        $display("FAIL %s (cycle %0d): got %h, expected %h", name_of(cur.sel), cyc, act, cur.val);
      end
    end
  end

  task automatic expect_val(input int sel, input logic [31:0] v);
    exp_t e;
    e.cyc = cyc;
    e.sel = sel;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic expect_ctrl(input logic s, input logic h, input logic f,
                             input int cnt, input logic r);
    expect_val(S_START, {31'd0, s});
    expect_val(S_HALT,  {31'd0, h});
    expect_val(S_FULL,  {31'd0, f});
    expect_val(S_COUNT, 32'(cnt));
    expect_val(S_READY, {31'd0, r});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    load_valid = 1'b1;
    load_byte  = b;
    step();
    load_valid = 1'b0;
  endtask

  task automatic pulse_done();
    load_done = 1'b1;
    step();
    load_done = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    step();
    step();
    // Reset values
    expect_val(S_INSTR, HALT);
    expect_ctrl(1'b0, 1'b0, 1'b0, 0, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    expect_ctrl(1'b0, 1'b0, 1'b0, 0, 1'b1);

    // A: 01..04 -> word0 = 04030201
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    expect_ctrl(1'b0, 1'b0, 1'b0, 1, 1'b1);
    pulse_done();
    pc = 32'd0;
    expect_ctrl(1'b1, 1'b0, 1'b0, 1, 1'b0);
    expect_val(S_INSTR, 32'h0403_0201);
    step();
    expect_val(S_START, 32'd0);
    expect_val(S_HALT, 32'd0);
    expect_val(S_INSTR, 32'h0403_0201);
    step();
    pc = 32'd4;
    expect_val(S_INSTR, HALT);
    expect_val(S_HALT, 32'd1);
    step();
    pc = 32'd0;
    expect_val(S_INSTR, 32'h0403_0201);
    expect_val(S_HALT, 32'd1);
    step();
    pc = 32'd8;
    expect_val(S_HALT, 32'd1);

    // B: flush, then 5 bytes AA..EE -> word1 zero-padded
    pulse_flush();
    pc = 32'd0;
    expect_ctrl(1'b0, 1'b0, 1'b0, 0, 1'b1);
    expect_val(S_INSTR, HALT);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD); send_byte(8'hEE);
    expect_val(S_COUNT, 32'd1);
    pulse_done();
    pc = 32'd4;
    expect_ctrl(1'b1, 1'b0, 1'b0, 2, 1'b0);
    expect_val(S_INSTR, 32'h0000_00EE);
    step();
    pc = 32'd0;
    expect_val(S_INSTR, 32'hDDCC_BBAA);
    expect_val(S_HALT, 32'd0);
    step();
    pc = 32'd8;
    expect_val(S_INSTR, HALT);
    expect_val(S_HALT, 32'd1);

    // C: byte together with done, low pc bits ignored, out-of-range pc
    pulse_flush();
    expect_val(S_COUNT, 32'd0);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    load_valid = 1'b1;
    load_byte  = 8'h55;
    load_done  = 1'b1;
    step();
    load_valid = 1'b0;
    load_done  = 1'b0;
    pc = 32'd7;
    expect_ctrl(1'b1, 1'b0, 1'b0, 2, 1'b0);
    expect_val(S_INSTR, 32'h0000_0055);
    step();
    pc = 32'd1;
    expect_val(S_INSTR, 32'h4433_2211);
    expect_val(S_HALT, 32'd0);
    step();
    pc = 32'd5;
    expect_val(S_INSTR, 32'h0000_0055);
    step();
    pc = 32'h0000_0100;
    expect_val(S_INSTR, HALT);
    expect_val(S_HALT, 32'd1);

    // D: empty program
    pulse_flush();
    pulse_done();
    pc = 32'd0;
    expect_ctrl(1'b1, 1'b0, 1'b0, 0, 1'b0);
    expect_val(S_INSTR, HALT);
    step();
    expect_val(S_START, 32'd0);
    expect_val(S_HALT, 32'd1);

    // E: fill memory, extra bytes dropped
    pulse_flush();
    expect_ctrl(1'b0, 1'b0, 1'b0, 0, 1'b1);
    for (int k = 0; k < 260; k++) begin
      b = (k < 256) ? 8'(k) : 8'h5A;
      send_byte(b);
      if (k == 251) expect_ctrl(1'b0, 1'b0, 1'b0, 63, 1'b1);
      if (k == 255) expect_ctrl(1'b0, 1'b0, 1'b1, 64, 1'b0);
      if (k == 259) expect_ctrl(1'b0, 1'b0, 1'b1, 64, 1'b0);
    end
    pulse_done();
    pc = 32'd0;
    expect_ctrl(1'b1, 1'b0, 1'b1, 64, 1'b0);
    expect_val(S_INSTR, 32'h0302_0100);
    step();
    pc = 32'd252;
    expect_val(S_INSTR, 32'hFFFE_FDFC);
    expect_val(S_HALT, 32'd0);
    step();
    pc = 32'd128;
    expect_val(S_INSTR, 32'h8382_8180);
    step();
    pc = 32'd256;
    expect_val(S_INSTR, HALT);
    expect_val(S_HALT, 32'd1);

    // F: reset mid-load
    pulse_flush();
    pc = 32'd0;
    expect_ctrl(1'b0, 1'b0, 1'b0, 0, 1'b1);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    rst_n = 1'b0;
    expect_val(S_INSTR, HALT);
    expect_ctrl(1'b0, 1'b0, 1'b0, 0, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    step();
    expect_val(S_READY, 32'd1);
    send_byte(8'h0A); send_byte(8'h0B); send_byte(8'h0C); send_byte(8'h0D);
    expect_val(S_COUNT, 32'd1);
    pulse_done();
    expect_ctrl(1'b1, 1'b0, 1'b0, 1, 1'b0);
    expect_val(S_INSTR, 32'h0D0C_0B0A);
    step();
    step();

    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d expectations never compared, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
